// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Direct-mapped branch target buffer with a per-entry saturating direction
// counter. Lookup is purely combinational from the fetch PC. Updates come
// from the resolve stage and land on the next rising clock edge, so a lookup
// in the same cycle as an update sees the old entry contents.
//
// Parameters
//   ENTRIES : table depth, power of two, 4..256 (IDX_W = log2(ENTRIES))
//   TAG_W   : stored tag width, 1..20
//   CNT_W   : saturating counter width, 1..4 (1 = last-direction bit)
//
// Ports
//   clk              in   1  rising-edge clock
//   rst              in   1  synchronous active-high reset
//   if_pc            in  32  fetch PC to predict
//   pred_taken       out  1  predict taken for if_pc
//   pred_target      out 32  predicted next PC
//   upd_valid        in   1  resolved control-transfer update strobe
//   upd_pc           in  32  PC of the resolved branch/jump
//   upd_taken        in   1  actual direction
//   upd_target       in  32  actual taken target
//   upd_mispredict   in   1  resolution disagreed with prediction
//   stat_updates     out 32  (BP_STATS_EN only) cycles with upd_valid
//   stat_mispredicts out 32  (BP_STATS_EN only) cycles with upd_valid and
//                            upd_mispredict
//
// Optional feature macro: BP_STATS_EN. When undefined the statistics ports
// and counters are absent and upd_mispredict is not used.
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_updates,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int IDX_W  = $clog2(ENTRIES);
    localparam int TAG_LO = IDX_W + 2;
    localparam int TAG_HI = IDX_W + TAG_W + 1;

    // Counter encodings. Written without zero-width replications so that
    // CNT_W = 1 elaborates cleanly: weak-taken is the MSB alone, the reset
    // value (weak not-taken) is everything below it.
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_WEAK_T = CNT_MAX ^ (CNT_MAX >> 1);
    localparam logic [CNT_W-1:0] CNT_RESET  = CNT_MAX >> 1;

    // -------------------------------------------------------------------------
    // Table storage
    // -------------------------------------------------------------------------
    logic             tbl_valid  [ENTRIES];
    logic [TAG_W-1:0] tbl_tag    [ENTRIES];
    logic [31:0]      tbl_target [ENTRIES];
    logic [CNT_W-1:0] tbl_cnt    [ENTRIES];

    // -------------------------------------------------------------------------
    // Lookup path (combinational)
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [31:0]      lk_fallthru;

    assign lk_idx      = if_pc[IDX_W+1:2];
    assign lk_tag      = if_pc[TAG_HI:TAG_LO];
    assign lk_hit      = tbl_valid[lk_idx] && (tbl_tag[lk_idx] == lk_tag);
    assign lk_fallthru = if_pc + 32'd4;

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = lk_fallthru;
        if (lk_hit && tbl_cnt[lk_idx][CNT_W-1]) begin
            pred_taken  = 1'b1;
            pred_target = tbl_target[lk_idx];
        end
    end

    // -------------------------------------------------------------------------
    // Update path
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic [CNT_W-1:0] up_cnt;
    logic [CNT_W-1:0] up_cnt_next;

    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[TAG_HI:TAG_LO];
    assign up_hit = tbl_valid[up_idx] && (tbl_tag[up_idx] == up_tag);
    assign up_cnt = tbl_cnt[up_idx];

    // Saturating step toward the resolved direction.
    always_comb begin
        up_cnt_next = up_cnt;
        if (upd_taken) begin
            if (up_cnt != CNT_MAX) begin
                up_cnt_next = up_cnt + CNT_W'(1);
            end
        end else begin
            if (up_cnt != '0) begin
                up_cnt_next = up_cnt - CNT_W'(1);
            end
        end
    end

    // Reset wins over any update in the same cycle. A not-taken miss leaves
    // the table alone: there is nothing worth remembering about a branch that
    // falls through and is not already tracked.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_valid[i]  <= 1'b0;
                tbl_tag[i]    <= '0;
                tbl_target[i] <= 32'd0;
                tbl_cnt[i]    <= CNT_RESET;
            end
        end else if (upd_valid) begin
            if (up_hit) begin
                tbl_cnt[up_idx] <= up_cnt_next;
                if (upd_taken) begin
                    tbl_target[up_idx] <= upd_target;
                end
            end else if (upd_taken) begin
                tbl_valid[up_idx]  <= 1'b1;
                tbl_tag[up_idx]    <= up_tag;
                tbl_target[up_idx] <= upd_target;
                tbl_cnt[up_idx]    <= CNT_WEAK_T;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Optional statistics
    // -------------------------------------------------------------------------
`ifdef BP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_updates     <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else if (upd_valid) begin
            stat_updates <= stat_updates + 32'd1;
            if (upd_mispredict) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

    // Update-PC bits outside index/tag do not select anything in the table.
    logic unused_bits;
`ifdef BP_STATS_EN
    assign unused_bits = ^{upd_pc[1:0], upd_pc[31:TAG_HI+1]};
`else
    assign unused_bits = ^{upd_pc[1:0], upd_pc[31:TAG_HI+1], upd_mispredict};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    localparam int ENTRIES = 16;
    localparam int TAG_W   = 8;
    localparam int CNT_W   = 2;

    localparam int HALF  = 2 ** (CNT_W - 1);
    localparam int CMAX  = 2 ** CNT_W - 1;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
`ifdef BP_STATS_EN
    logic [31:0] stat_updates;
    logic [31:0] stat_mispredicts;
`endif

    branch_predictor #(
        .ENTRIES(ENTRIES),
        .TAG_W  (TAG_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_pc         (if_pc),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .upd_mispredict(upd_mispredict)
`ifdef BP_STATS_EN
        ,
        .stat_updates    (stat_updates),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Behavioural model: the table as plain integers.
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_cnt   [ENTRIES];
    int unsigned m_stat_upd;
    int unsigned m_stat_mis;

    function automatic int unsigned m_index(input logic [31:0] pc);
        int unsigned p;
        p = pc;
        return (p / 4) % ENTRIES;
    endfunction

    function automatic int unsigned m_tagof(input logic [31:0] pc);
        int unsigned p;
        p = pc;
        return (p / (4 * ENTRIES)) % (2 ** TAG_W);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = 32'd0;
            m_cnt[i]   = HALF - 1;
        end
        m_stat_upd = 0;
        m_stat_mis = 0;
    endtask

    task automatic m_predict(input logic [31:0] pc, output logic t, output logic [31:0] tgt);
        int unsigned i;
        i   = m_index(pc);
        t   = m_valid[i] && (m_tag[i] == m_tagof(pc)) && (m_cnt[i] >= HALF);
        tgt = t ? m_tgt[i] : pc + 32'd4;
    endtask

    task automatic m_update(input logic [31:0] pc, input logic t, input logic [31:0] tgt, input logic mis);
        int unsigned i;
        i = m_index(pc);
        m_stat_upd++;
        if (mis) m_stat_mis++;
        if (m_valid[i] && m_tag[i] == m_tagof(pc)) begin
            if (t) begin
                m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
                m_tgt[i] = tgt;
            end else begin
                m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
            end
        end else if (t) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = m_tagof(pc);
            m_tgt[i]   = tgt;
            m_cnt[i]   = HALF;
        end
    endtask

    logic        obs_taken;
    logic [31:0] obs_target;
    logic [31:0] obs_stat_upd;
    logic [31:0] obs_stat_mis;

    // One clock: drive on the falling edge, compare lookup against the model
    // (pre-update state), then advance the model at the rising edge.
    task automatic cycle(input logic r, input logic [31:0] pc, input logic uv,
                         input logic [31:0] upc, input logic ut,
                         input logic [31:0] utgt, input logic um);
        logic        et;
        logic [31:0] etg;
        @(negedge clk);
        rst            = r;
        if_pc          = pc;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_taken      = ut;
        upd_target     = utgt;
        upd_mispredict = um;
        #1;
        m_predict(pc, et, etg);
        obs_taken  = pred_taken;
        obs_target = pred_target;
        check("mdl_taken", {31'b0, pred_taken}, {31'b0, et});
        check("mdl_target", pred_target, etg);
`ifdef BP_STATS_EN
        obs_stat_upd = stat_updates;
        obs_stat_mis = stat_mispredicts;
        check("mdl_stat_upd", stat_updates, m_stat_upd);
        check("mdl_stat_mis", stat_mispredicts, m_stat_mis);
`else
        obs_stat_upd = 32'd0;
        obs_stat_mis = 32'd0;
`endif
        @(posedge clk);
        if (r) m_reset();
        else if (uv) m_update(upc, ut, utgt, um);
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic et, input logic [31:0] etg);
        cycle(1'b0, pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        check({tag, "_taken"}, {31'b0, obs_taken}, {31'b0, et});
        check({tag, "_target"}, obs_target, etg);
    endtask

    task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
        cycle(1'b0, 32'h0000_1000, 1'b1, pc, t, tgt, 1'b0);
    endtask

    // Reset with a live allocating update that must be ignored.
    task automatic do_reset();
        cycle(1'b1, 32'h0000_0040, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0100, 1'b1);
    endtask

    initial begin
        rst            = 1'b1;
        if_pc          = 32'd0;
        upd_valid      = 1'b1;
        upd_pc         = 32'h0000_0040;
        upd_taken      = 1'b1;
        upd_target     = 32'h0000_0100;
        upd_mispredict = 1'b0;
        repeat (2) @(posedge clk);
        m_reset();

        // Reset state and first allocation
        look("rst_lookup", 32'h0000_0040, 1'b0, 32'h0000_0044);
        upd(32'h0000_0040, 1'b1, 32'h0000_0100);
        look("alloc", 32'h0000_0040, 1'b1, 32'h0000_0100);

        // Counter walk: 2 ->1 ->0 ->0 ->1 ->2 ->3 ->3 ->2 ->1
        upd(32'h0000_0040, 1'b0, 32'd0);
        look("nt1", 32'h0000_0040, 1'b0, 32'h0000_0044);
        upd(32'h0000_0040, 1'b0, 32'd0);
        look("nt2", 32'h0000_0040, 1'b0, 32'h0000_0044);
        upd(32'h0000_0040, 1'b0, 32'd0);
        look("nt_sat0", 32'h0000_0040, 1'b0, 32'h0000_0044);
        upd(32'h0000_0040, 1'b1, 32'h0000_0100);
        look("t_to1", 32'h0000_0040, 1'b0, 32'h0000_0044);
        upd(32'h0000_0040, 1'b1, 32'h0000_0100);
        look("t_to2", 32'h0000_0040, 1'b1, 32'h0000_0100);
        upd(32'h0000_0040, 1'b1, 32'h0000_0100);
        upd(32'h0000_0040, 1'b1, 32'h0000_0300);
        look("t_sat3_newtgt", 32'h0000_0040, 1'b1, 32'h0000_0300);
        upd(32'h0000_0040, 1'b0, 32'd0);
        look("sat3_then_nt", 32'h0000_0040, 1'b1, 32'h0000_0300);
        upd(32'h0000_0040, 1'b0, 32'd0);
        look("down_to1", 32'h0000_0040, 1'b0, 32'h0000_0044);

        // Mid-operation reset discards everything
        upd(32'h0000_0040, 1'b1, 32'h0000_0100);
        do_reset();
        look("midop_rst", 32'h0000_0040, 1'b0, 32'h0000_0044);

        // Aliasing: same index, different tag replaces the entry
        upd(32'h0000_0040, 1'b1, 32'h0000_0100);
        upd(32'h0000_0080, 1'b1, 32'h0000_0200);
        look("alias_old", 32'h0000_0040, 1'b0, 32'h0000_0044);
        look("alias_new", 32'h0000_0080, 1'b1, 32'h0000_0200);
        upd(32'h0000_00C0, 1'b0, 32'h0000_0500);
        look("nt_miss_keep", 32'h0000_0080, 1'b1, 32'h0000_0200);

        // Same-cycle lookup and allocating update
        do_reset();
        cycle(1'b0, 32'h0000_0040, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0100, 1'b0);
        check("samecyc_taken", {31'b0, obs_taken}, 32'd0);
        look("samecyc_next", 32'h0000_0040, 1'b1, 32'h0000_0100);

`ifdef BP_STATS_EN
        do_reset();
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 32'd0, 1'b1, 32'h0000_0200 + 32'(i * 4), 1'b1, 32'h0000_0800, (i < 2) ? 1'b1 : 1'b0);
        look("stat_pre", 32'h0000_0010, 1'b0, 32'h0000_0014);
        check("stat_upd_5", obs_stat_upd, 32'd5);
        check("stat_mis_2", obs_stat_mis, 32'd2);
        do_reset();
        look("stat_post", 32'h0000_0010, 1'b0, 32'h0000_0014);
        check("stat_upd_0", obs_stat_upd, 32'd0);
        check("stat_mis_0", obs_stat_mis, 32'd0);
`endif

        // Randomized traffic over a small PC pool to get plenty of hits/aliasing
        for (int n = 0; n < 600; n++) begin
            logic [31:0] lpc, upc, tgt;
            logic        uv, ut, um, r;
            lpc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2)
                | 32'($urandom_range(0, 3)) | (32'($urandom_range(0, 1)) << 20);
            upc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2)
                | 32'($urandom_range(0, 3)) | (32'($urandom_range(0, 1)) << 20);
            tgt = $urandom;
            uv  = ($urandom_range(0, 9) < 6);
            ut  = $urandom_range(0, 1) != 0;
            um  = $urandom_range(0, 1) != 0;
            r   = ($urandom_range(0, 59) == 0);
            if (n == 599) lpc = 32'hFFFF_FFFC;
            cycle(r, lpc, uv, upc, ut, tgt, um);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have one clock, clk; reset is rst, synchronous, active-high.
REQ-002 The block SHALL expose parameter ENTRIES, default 16, table depth (power of two, 4..256); IDX_W = log2(ENTRIES).
REQ-003 The block SHALL expose parameter TAG_W, default 8, stored tag width (1..20).
REQ-004 The block SHALL expose parameter CNT_W, default 2, saturating counter width (1..4).
REQ-005 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-006 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port if_pc, input, 32, fetch PC to predict.
REQ-008 The block SHALL have port pred_taken, output, 1, predict taken for if_pc.
REQ-009 The block SHALL have port pred_target, output, 32, predicted next PC.
REQ-010 The block SHALL have port upd_valid, input, 1, resolved control-transfer update strobe from ID.
REQ-011 The block SHALL have port upd_pc, input, 32, PC of resolved branch/jump.
REQ-012 The block SHALL have port upd_taken, input, 1, actual direction.
REQ-013 The block SHALL have port upd_target, input, 32, actual taken target.
REQ-014 The block SHALL have port upd_mispredict, input, 1, resolution disagreed with prediction (flush issued).

Function
REQ-015 Index SHALL be pc[IDX_W+1:2]; tag SHALL be pc[IDX_W+TAG_W+1:IDX_W+2].
REQ-016 Each entry SHALL hold valid (1), tag (TAG_W), target (32), counter (CNT_W).
REQ-017 Lookup SHALL be combinational from if_pc: hit = valid && tag match.
REQ-018 pred_taken SHALL be hit && counter MSB == 1; pred_target SHALL be the entry target when pred_taken, else if_pc + 4 (mod 2^32).
REQ-019 Updates SHALL take effect at the rising edge after upd_valid; a lookup in the same cycle as an update to the same entry SHALL return pre-update contents.
REQ-020 On update with tag hit, the counter SHALL increment if upd_taken, else decrement, saturating at 2^CNT_W-1 and 0; target SHALL be overwritten with upd_target when upd_taken.
REQ-021 On update with tag miss and upd_taken=1, the entry SHALL be allocated: valid=1, new tag, target=upd_target, counter=2^(CNT_W-1) (weakly taken).
REQ-022 On update with tag miss and upd_taken=0, the table SHALL be unchanged.
REQ-023 upd_pc[1:0] and upd_target[1:0] SHALL be stored/compared unmodified (no alignment checks).
REQ-024 With CNT_W=1, the counter SHALL act as last-direction bit.

Reset
REQ-025 While rst=1 at a clock edge, all valid bits SHALL clear, counters SHALL become 2^(CNT_W-1)-1, targets SHALL become 0; upd_valid in that cycle SHALL be ignored.
REQ-026 After reset, pred_taken SHALL be 0 and pred_target SHALL equal if_pc + 4 for every if_pc until an allocation occurs.
REQ-027 Reset asserted mid-operation SHALL discard all learned state in one cycle.

Configuration
REQ-028 When BP_STATS_EN is defined, the block SHALL add outputs stat_updates (32) and stat_mispredicts (32), counting cycles with upd_valid and with upd_valid && upd_mispredict, wrapping mod 2^32, cleared by rst.
REQ-029 When BP_STATS_EN is undefined, those ports and counters SHALL be absent and upd_mispredict SHALL be ignored.

Verification
REQ-030 Reset, then if_pc=0x0000_0040 -> pred_taken=0, pred_target=0x0000_0044.
REQ-031 Update upd_pc=0x40, taken, target=0x100; next cycle if_pc=0x40 -> pred_taken=1, pred_target=0x100.
REQ-032 After REQ-031, two not-taken updates at 0x40 -> pred_taken=0 after first (counter 1), counter saturates at 0 after second; three taken updates -> counter 3, fourth taken stays 3.
REQ-033 ENTRIES=16: allocate 0x40 -> 0x100, then taken update 0x80 (same index, different tag) -> 0x200; lookup 0x40 -> miss, pred_target=0x44.
REQ-034 Same-cycle lookup and allocating update at 0x40 -> lookup shows pred_taken=0; following cycle pred_taken=1.
REQ-035 BP_STATS_EN: 5 updates, 2 with upd_mispredict, then rst -> counters 5/2 before reset, 0/0 after.
